// File: rtl/note_tile_renderer.sv
// Staff-region tile renderer: 64x8 tile map -> glyph ROM -> 1 bit per pixel, 2-cycle pipeline.
// Optional cursor-column inversion is enabled by defining NOTE_RENDER_CURSOR_EN.
module note_tile_renderer #(
    parameter int ORIGIN_X = 64,
    parameter int ORIGIN_Y = 200
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       pix_valid_in,
    input  logic       wr_en,
    input  logic [8:0] wr_addr,
    input  logic [4:0] wr_code,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_data,
    input  logic       frame_start,
    input  logic [5:0] cursor_col,
    output logic       pixel_on,
    output logic       pixel_valid,
    output logic       busy
);
    localparam int STAGES = 1;
    localparam logic [10:0] X_LO = 11'(ORIGIN_X);
    localparam logic [10:0] X_HI = 11'(ORIGIN_X + 512);
    localparam logic [10:0] Y_LO = 11'(ORIGIN_Y);
    localparam logic [10:0] Y_HI = 11'(ORIGIN_Y + 64);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t     state, state_nxt;
    logic [8:0] clr_cnt, clr_cnt_nxt;
    logic       tm_we;
    logic [8:0] tm_waddr;
    logic [4:0] tm_wdata;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // The clear sweep owns the map write port; host writes are dropped until RUN.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        busy        = 1'b0;
        tm_we       = 1'b0;
        tm_waddr    = wr_addr;
        tm_wdata    = wr_code;
        case (state)
            CLEAR: begin
                busy        = 1'b1;
                tm_we       = 1'b1;
                tm_waddr    = clr_cnt;
                tm_wdata    = '0;
                clr_cnt_nxt = clr_cnt + 9'd1;
                if (clr_cnt == 9'd511) state_nxt = RUN;
            end
            RUN: begin
                tm_we = wr_en;
            end
            default: state_nxt = CLEAR;
        endcase
    end

    // Stage 0: region test and tile address from the raw coordinate.
    logic [9:0] dx, dy;
    logic       in_region;
    logic [8:0] rd_addr;
    logic       cur_hit;
    logic       unused_bits;

    assign dx        = DrawX - X_LO[9:0];
    assign dy        = DrawY - Y_LO[9:0];
    assign in_region = ({1'b0, DrawX} >= X_LO) && ({1'b0, DrawX} < X_HI) &&
                       ({1'b0, DrawY} >= Y_LO) && ({1'b0, DrawY} < Y_HI);
    assign rd_addr   = {dy[5:3], dx[8:3]};

`ifdef NOTE_RENDER_CURSOR_EN
    logic [5:0] cursor_q;

    // The compare uses the pre-update cursor_q, so a same-cycle frame_start affects later pixels only.
    always_ff @(posedge Clk) begin
        if (Reset)            cursor_q <= '0;
        else if (frame_start) cursor_q <= cursor_col;
    end

    assign cur_hit     = in_region && pix_valid_in && (dx[8:3] == cursor_q);
    assign unused_bits = ^{dx[9], dy[9:6]};
`else
    assign cur_hit     = 1'b0;
    assign unused_bits = ^{dx[9], dy[9:6], frame_start, cursor_col};
`endif

    // Tile map: registered read sees the pre-write contents on an address collision.
    logic [4:0] tmap [512];
    logic [4:0] s1_code;

    always_ff @(posedge Clk) begin
        if (tm_we) tmap[tm_waddr] <= tm_wdata;
        s1_code <= tmap[rd_addr];
    end

    // Stage 1 registers.
    logic [STAGES:0] vld_pipe;
    logic            s1_inr, s1_run, s1_cur;
    logic [2:0]      s1_row, s1_bit;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            vld_pipe <= '0;
            s1_inr   <= 1'b0;
            s1_run   <= 1'b0;
            s1_cur   <= 1'b0;
            s1_row   <= '0;
            s1_bit   <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], pix_valid_in};
            s1_inr   <= in_region;
            s1_run   <= (state == RUN);
            s1_cur   <= cur_hit;
            s1_row   <= dy[2:0];
            s1_bit   <= dx[2:0];
        end
    end

    // Stage 2: glyph lookup and output register.
    assign rom_addr    = {(s1_inr ? s1_code : 5'd0), s1_row};
    assign pixel_valid = vld_pipe[STAGES];

    always_ff @(posedge Clk) begin
        if (Reset) pixel_on <= 1'b0;
        else       pixel_on <= vld_pipe[0] & s1_inr & s1_run &
                               (rom_data[3'd7 - s1_bit] ^ s1_cur);
    end

endmodule

// File: tb/tb_note_tile_renderer.sv
// Bench for note_tile_renderer: abstract tile-map/pixel model checked every cycle plus directed literals.
module tb_note_tile_renderer;
    localparam int OX = 64;
    localparam int OY = 200;
`ifdef NOTE_RENDER_CURSOR_EN
    localparam bit CUR_EN = 1'b1;
`else
    localparam bit CUR_EN = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [9:0] DrawX = '0, DrawY = '0;
    logic       pix_valid_in = 1'b0;
    logic       wr_en = 1'b0;
    logic [8:0] wr_addr = '0;
    logic [4:0] wr_code = '0;
    logic [7:0] rom_addr, rom_data;
    logic       frame_start = 1'b0;
    logic [5:0] cursor_col = '0;
    logic       pixel_on, pixel_valid, busy;

    note_tile_renderer #(.ORIGIN_X(OX), .ORIGIN_Y(OY)) dut (
        .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
        .pix_valid_in(pix_valid_in), .wr_en(wr_en), .wr_addr(wr_addr), .wr_code(wr_code),
        .rom_addr(rom_addr), .rom_data(rom_data), .frame_start(frame_start),
        .cursor_col(cursor_col), .pixel_on(pixel_on), .pixel_valid(pixel_valid), .busy(busy)
    );

    always #5 Clk = ~Clk;

    function automatic logic [7:0] glyph(input logic [4:0] code, input logic [2:0] row);
        if (code == 5'd0) return 8'h00;
        if (code == 5'd1) return 8'h18;
        return {code[2:0], row, 2'b10};
    endfunction

    assign rom_data = glyph(rom_addr[7:3], rom_addr[2:0]);

    typedef struct packed {
        logic       v;
        logic       on;
        logic       chk;
        logic [7:0] addr;
    } exp_t;

    exp_t       e1, e2;
    int         clr_left;
    int         mcur;
    logic [4:0] mt [512];
    bit         model_ok = 1'b0;
    int         checks = 0;
    int         errors = 0;

    // Model: what each pixel must show given the map as it stood when the pixel arrived.
    always @(posedge Clk) begin : model
        int dx, dy, row, bp, col, code;
        bit inr, run, hit;
        logic [7:0] g;
        if (Reset) begin
            e1 = '0; e2 = '0; clr_left = 512; mcur = 0; model_ok = 1'b1;
            foreach (mt[i]) mt[i] = 5'd0;
        end else begin
            dx   = int'(DrawX) - OX;
            dy   = int'(DrawY) - OY;
            inr  = dx >= 0 && dx < 512 && dy >= 0 && dy < 64;
            row  = ((dy % 8) + 8) % 8;
            bp   = ((dx % 8) + 8) % 8;
            col  = inr ? dx / 8 : 0;
            code = inr ? int'(mt[(dy / 8) * 64 + col]) : 0;
            run  = (clr_left == 0);
            hit  = CUR_EN && inr && pix_valid_in && (col == mcur);
            g    = glyph(code[4:0], row[2:0]);
            e2     = e1;
            e1.v   = pix_valid_in;
            e1.on  = pix_valid_in && inr && run && (g[7 - bp] ^ hit);
            e1.chk = run;
            e1.addr = {code[4:0], row[2:0]};
            if (CUR_EN && frame_start) mcur = int'(cursor_col);
            if (run) begin
                if (wr_en) mt[wr_addr] = wr_code;
            end else begin
                clr_left--;
            end
        end
    end

    always @(negedge Clk) begin
        if (model_ok) begin
            checks++;
            if (pixel_valid !== e2.v || pixel_on !== e2.on) begin
                errors++;
                $display("FAIL model_pix t=%0t valid,on got %b,%b want %b,%b",
                         $time, pixel_valid, pixel_on, e2.v, e2.on);
            end
            if (e1.chk) begin
                checks++;
                if (rom_addr !== e1.addr) begin
                    errors++;
                    $display("FAIL model_rom_addr t=%0t got %h want %h", $time, rom_addr, e1.addr);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic pix_lit(input string name, input int x, input int y,
                           input logic [7:0] want_addr, input logic want_on);
        @(negedge Clk);
        DrawX = 10'(x); DrawY = 10'(y); pix_valid_in = 1'b1;
        @(negedge Clk);
        chk({name, "_addr"}, 32'(rom_addr), 32'(want_addr));
        pix_valid_in = 1'b0;
        @(negedge Clk);
        chk({name, "_on"}, 32'(pixel_on), 32'(want_on));
        chk({name, "_valid"}, 32'(pixel_valid), 32'd1);
    endtask

    task automatic write_tile(input logic [8:0] a, input logic [4:0] c);
        @(negedge Clk);
        wr_en = 1'b1; wr_addr = a; wr_code = c;
        @(negedge Clk);
        wr_en = 1'b0;
    endtask

    // Caller holds Reset high; release it and count cycles until busy drops.
    task automatic count_clear(input string name);
        int n;
        n = 0;
        @(negedge Clk);
        Reset = 1'b0;
        do begin
            @(posedge Clk);
            #1;
            n++;
        end while (busy && n < 600);
        chk(name, 32'(n), 32'd512);
    endtask

    initial begin
        repeat (2) @(negedge Clk);
        chk("reset_busy", 32'(busy), 32'd1);
        chk("reset_valid", 32'(pixel_valid), 32'd0);
        chk("reset_on", 32'(pixel_on), 32'd0);

        // Host writes during the clear must be dropped.
        wr_en = 1'b1; wr_addr = 9'h000; wr_code = 5'd5;
        count_clear("clear_len");
        @(negedge Clk);
        wr_en = 1'b0;
        frame_start = 1'b1; cursor_col = 6'd40;
        @(negedge Clk);
        frame_start = 1'b0;
        pix_lit("wr_in_clear", 67, 203, 8'h03, 1'b0);

        write_tile(9'h000, 5'd1);
        pix_lit("glyph_hit", 67, 203, 8'h0B, 1'b1);
        pix_lit("glyph_msb", 64, 201, 8'h09, 1'b0);

        write_tile(9'h1FF, 5'd2);
        pix_lit("last_tile", 575, 263, 8'h17, 1'b0);
        pix_lit("past_right", 576, 263, 8'h07, 1'b0);

        // Read-before-write on the same tile.
        @(negedge Clk);
        wr_en = 1'b1; wr_addr = 9'h000; wr_code = 5'd3;
        DrawX = 10'd64; DrawY = 10'd200; pix_valid_in = 1'b1;
        @(negedge Clk);
        chk("rbw_old", 32'(rom_addr), 32'h08);
        wr_en = 1'b0;
        @(negedge Clk);
        chk("rbw_new", 32'(rom_addr), 32'h18);
        pix_valid_in = 1'b0;

        // Cursor on column 0 over a blank tile.
        write_tile(9'h000, 5'd0);
        @(negedge Clk);
        frame_start = 1'b1; cursor_col = 6'd0;
        @(negedge Clk);
        frame_start = 1'b0;
        pix_lit("cursor_x64", 64, 200, 8'h00, CUR_EN);
        pix_lit("cursor_x71", 71, 200, 8'h00, CUR_EN);
        pix_lit("cursor_x72", 72, 200, 8'h00, 1'b0);

        // frame_start alongside a pixel: that pixel still sees the old cursor.
        @(negedge Clk);
        frame_start = 1'b1; cursor_col = 6'd9;
        DrawX = 10'd64; DrawY = 10'd200; pix_valid_in = 1'b1;
        @(negedge Clk);
        frame_start = 1'b0;
        @(negedge Clk);
        chk("cursor_same_cycle", 32'(pixel_on), 32'(CUR_EN));
        pix_valid_in = 1'b0;
        @(negedge Clk);
        chk("cursor_moved", 32'(pixel_on), 32'd0);

        // Back-to-back stream with interleaved writes, gaps and cursor moves.
        for (int i = 0; i < 48; i++) begin
            @(negedge Clk);
            DrawX = 10'(56 + (i % 24));
            DrawY = 10'(198 + i / 8);
            pix_valid_in = ((i % 7) != 3);
            wr_en = ((i % 6) == 0);
            wr_addr = 9'(i % 3);
            wr_code = 5'(i % 4);
            frame_start = (i == 20);
            cursor_col = 6'd1;
        end
        @(negedge Clk);
        wr_en = 1'b0; frame_start = 1'b0;

        // Reset mid-RUN with pixels in flight, then again mid-CLEAR.
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk("rerun_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            DrawX = 10'(60 + (i % 16)); DrawY = 10'd200; pix_valid_in = 1'b1;
        end
        @(negedge Clk);
        pix_valid_in = 1'b0;
        Reset = 1'b1;
        count_clear("clear_len_again");
        pix_lit("after_reclear", 67, 203, 8'h03, CUR_EN);
        repeat (3) @(negedge Clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
